// File: rtl/ahb_rom1k16.sv
// ahb_rom1k16: AHB-Lite read-only slave for a 1K x 16 synchronous-read memory.
// Reads stall MEM_LAT+1 cycles for the memory; writes get a two-cycle ERROR.
module ahb_rom1k16 #(
   parameter int MEM_LAT = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [9:0]  mem_addr,
   output logic        mem_re,
   input  logic [15:0] mem_rdata
);
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, ERR1, ERR2} state_t;
   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] rdata_q, rdata_d;
   logic [9:0]  addr_q, addr_d;
   logic        re_q, re_d, rdy_q, rdy_d, resp_q, resp_d;
   logic        acc;
   logic        unused;
   assign unused = ^{HSIZE, HADDR[31:12], HADDR[1:0], HTRANS[0]};
   always_comb begin
      acc     = HSEL & HREADY & HTRANS[1] & rdy_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      re_d    = 1'b0;
      if (state_q == RD_WAIT) begin
         cnt_d = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
         if (cnt_q == 2'd0) begin
            rdata_d = mem_rdata;
            state_d = RD_DONE;
         end
      end else if (state_q == ERR1) begin
         state_d = ERR2;
      end else if (acc && HWRITE) begin
         state_d = ERR1;
      end else if (acc) begin
         state_d = RD_WAIT;
         addr_d  = HADDR[11:2];
         re_d    = 1'b1;
         cnt_d   = 2'(MEM_LAT);
      end else begin
         state_d = IDLE;
      end
      rdy_d  = (state_d == IDLE) || (state_d == RD_DONE) || (state_d == ERR2);
      resp_d = (state_d == ERR1) || (state_d == ERR2);
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         rdata_q <= 16'h0000;
         addr_q  <= 10'd0;
         re_q    <= 1'b0;
         rdy_q   <= 1'b1;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         re_q    <= re_d;
         rdy_q   <= rdy_d;
         resp_q  <= resp_d;
      end
   end
   assign HRDATA    = {16'h0000, rdata_q};
   assign HREADYOUT = rdy_q;
   assign HRESP     = resp_q;
   assign mem_addr  = addr_q;
   assign mem_re    = re_q;
endmodule

// File: tb/tb_ahb_rom1k16.sv
// tb_ahb_rom1k16: randomized scoreboard bench for ahb_rom1k16 at MEM_LAT 1 and 3.
module tb_ahb_rom1k16;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst [2];
   logic        hsel [2];
   logic [31:0] haddr [2];
   logic [1:0]  htrans [2];
   logic        hwrite [2];
   logic [2:0]  hsize [2];
   logic        hready [2];
   logic [31:0] hrdata [2];
   logic        hreadyout [2];
   logic        hresp [2];
   logic [9:0]  mem_addr [2];
   logic        mem_re [2];
   logic [15:0] mem_rdata [2];
   logic [15:0] mem [1024];
   int          n_cmp = 0, n_bad = 0;
   logic        acc_v;
   typedef struct {
      logic        wr;
      logic [9:0]  word;
      logic [31:0] data;
   } exp_t;
   function automatic logic [9:0] word_of(input logic [31:0] a);
      return 10'((a / 4) % 1024);
   endfunction
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int LAT = (g == 0) ? 1 : 3;
      exp_t        q[$];
      logic [15:0] pipe [3];
      logic        rdy_s;
      logic        chk_rst = 1'b0;
      int          waits = 0, res = 0;
      logic [31:0] last = 32'd0;
      ahb_rom1k16 #(.MEM_LAT(LAT)) dut (
         .CLK(clk), .RST(rst[g]), .HSEL(hsel[g]), .HADDR(haddr[g]), .HTRANS(htrans[g]),
         .HWRITE(hwrite[g]), .HSIZE(hsize[g]), .HREADY(hready[g]), .HRDATA(hrdata[g]),
         .HREADYOUT(hreadyout[g]), .HRESP(hresp[g]), .mem_addr(mem_addr[g]),
         .mem_re(mem_re[g]), .mem_rdata(mem_rdata[g])
      );
      // Memory model: data valid only for the one cycle it is due, garbage otherwise
      always @(posedge clk) begin
         pipe[0] <= mem_re[g] ? mem[mem_addr[g]] : 16'($urandom);
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign mem_rdata[g] = pipe[LAT-1];
      task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, g, $time, got, want);
         end
      endtask
      always @(posedge clk) begin
         if (rst[g]) begin
            q.delete();
            last <= 32'd0;
         end else if (hsel[g] && hready[g] && htrans[g][1] && rdy_s) begin
            q.push_back('{hwrite[g], word_of(haddr[g]),
                          hwrite[g] ? last : {16'h0, mem[word_of(haddr[g])]}});
            if (!hwrite[g]) last <= {16'h0, mem[word_of(haddr[g])]};
         end
      end
      always @(negedge clk) begin
         rdy_s <= hreadyout[g];
         if (rst[g]) begin
            waits   <= 0;
            res     <= 0;
            chk_rst <= 1'b1;
         end else begin
            if (chk_rst) begin
               chk("rst_hrdata", hrdata[g], 32'd0);
               chk("rst_ready", 32'(hreadyout[g]), 32'd1);
               chk_rst <= 1'b0;
            end
            if (q.size() == 0) begin
               chk("idle_rdy_resp_re", {29'd0, hreadyout[g], hresp[g], mem_re[g]}, 32'd4);
               chk("idle_hrdata", hrdata[g], last);
            end else begin
               if (mem_re[g]) chk("mem_addr", 32'(mem_addr[g]), 32'(q[0].word));
               if (!hreadyout[g]) begin
                  waits <= waits + 1;
                  res   <= res + (mem_re[g] ? 1 : 0);
                  chk("wait_resp", 32'(hresp[g]), 32'(q[0].wr));
               end else begin
                  chk("done_resp", 32'(hresp[g]), 32'(q[0].wr));
                  chk("hrdata", hrdata[g], q[0].data);
                  chk("wait_states", 32'(waits), q[0].wr ? 32'd1 : 32'(LAT + 1));
                  chk("mem_re_pulses", 32'(res + (mem_re[g] ? 1 : 0)), q[0].wr ? 32'd0 : 32'd1);
                  void'(q.pop_front());
                  waits <= 0;
                  res   <= 0;
               end
            end
         end
      end
   end
   task automatic cyc(input int d, input logic r, input logic s, input logic [31:0] a,
                      input logic [1:0] t, input logic w, input logic rd, output logic acc);
      logic ok;
      rst[d] = r; hsel[d] = s; haddr[d] = a; htrans[d] = t;
      hwrite[d] = w; hready[d] = rd; hsize[d] = 3'($urandom);
      @(negedge clk);
      ok = hreadyout[d];
      @(posedge clk);
      #1;
      acc = !r && s && rd && t[1] && ok;
   endtask
   task automatic xfer(input int d, input logic [31:0] a, input logic w);
      logic acc = 1'b0;
      int   i = 0;
      while (!acc && i < 12) begin
         cyc(d, 1'b0, 1'b1, a, 2'b10, w, 1'b1, acc);
         i++;
      end
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL xfer_timeout dut%0d addr=%0h got=not_accepted want=accepted", d, a);
      end
   endtask
   task automatic idle(input int d, input int n);
      logic acc;
      repeat (n) cyc(d, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, acc);
   endtask
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      mem[2] = 16'hBEEF;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; hsel[d] = 1'b0; haddr[d] = 32'd0; htrans[d] = 2'b00;
         hwrite[d] = 1'b0; hsize[d] = 3'd1; hready[d] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      idle(0, 2);
      xfer(0, 32'h0000_0008, 1'b0);
      idle(0, 4);
      xfer(0, 32'h0000_0004, 1'b0);
      xfer(0, 32'h0000_0008, 1'b0);
      xfer(0, 32'h0000_0FFC, 1'b0);
      idle(0, 4);
      xfer(0, 32'h0000_0010, 1'b1);
      xfer(0, 32'h0000_0008, 1'b0);
      idle(0, 4);
      cyc(0, 1'b0, 1'b1, 32'h20, 2'b00, 1'b0, 1'b1, acc_v);
      cyc(0, 1'b0, 1'b1, 32'h20, 2'b01, 1'b0, 1'b1, acc_v);
      cyc(0, 1'b0, 1'b0, 32'h20, 2'b10, 1'b0, 1'b1, acc_v);
      cyc(0, 1'b0, 1'b1, 32'h20, 2'b10, 1'b0, 1'b0, acc_v);
      idle(0, 2);
      xfer(0, 32'h0000_0040, 1'b0);
      cyc(0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, acc_v);
      idle(0, 1);
      xfer(0, 32'h0000_0040, 1'b0);
      idle(0, 1);
      cyc(0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, acc_v);
      idle(0, 1);
      xfer(0, 32'h0000_0044, 1'b0);
      idle(0, 4);
      xfer(1, 32'h0000_1004, 1'b0);
      idle(1, 6);
      xfer(1, 32'hABCD_0008, 1'b0);
      xfer(1, 32'h0000_0013, 1'b0);
      xfer(1, 32'h0000_0FFC, 1'b1);
      xfer(1, 32'h0000_0FFC, 1'b0);
      idle(1, 6);
      for (int d = 0; d < 2; d++) begin
         repeat (400) cyc(d, $urandom_range(149) == 0, $urandom_range(3) != 0, $urandom,
                          2'($urandom), $urandom_range(3) == 0, $urandom_range(7) != 0, acc_v);
         idle(d, 8);
      end
      n_cmp++;
      if (u[0].q.size() != 0) begin
         n_bad++;
         $display("FAIL drain dut0 got=%0d want=0", u[0].q.size());
      end
      n_cmp++;
      if (u[1].q.size() != 0) begin
         n_bad++;
         $display("FAIL drain dut1 got=%0d want=0", u[1].q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
